// File: rtl/dataload_pkg.sv
// Shared types and sizing for the dataload/dataunload pair.
package dataload_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned NUM_WORDS  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unload_state_t;

    typedef logic [WORD_WIDTH*NUM_WORDS-1:0] result_vec_t;

endpackage

// File: rtl/dataunload.sv
// Result serializer: captures a parallel result vector and streams it out one word per handshake.
// Optional macro DATAUNLOAD_MSW_FIRST_EN reverses word order (most-significant word first).
module dataunload #(
    parameter int unsigned WORD_WIDTH = dataload_pkg::WORD_WIDTH,
    parameter int unsigned NUM_WORDS  = dataload_pkg::NUM_WORDS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WORD_WIDTH*NUM_WORDS-1:0] result_i,
    input  logic                           result_valid_i,
    output logic                           result_ready_o,
    output logic [WORD_WIDTH-1:0]          data_o,
    output logic                           data_valid_o,
    input  logic                           data_ready_i,
    output logic                           unload_done_o
);

    import dataload_pkg::unload_state_t;
    import dataload_pkg::IDLE;
    import dataload_pkg::SEND;

    localparam int unsigned VEC_W = WORD_WIDTH * NUM_WORDS;
    localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    unload_state_t           state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [VEC_W-1:0]        cap_q, cap_d;
    logic [WORD_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic                    last_word;

    // Maps a send position to the word it carries.
    function automatic logic [WORD_WIDTH-1:0] sel_word(input logic [VEC_W-1:0] vec,
                                                        input logic [CNT_W-1:0] pos);
        int unsigned idx;
`ifdef DATAUNLOAD_MSW_FIRST_EN
        idx = NUM_WORDS - 1 - 32'(pos);
`else
        idx = 32'(pos);
`endif
        return vec[idx*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    assign last_word      = (cnt_q == LAST_CNT);
    // Opens on the last-word handshake so the next vector follows with no bubble.
    assign result_ready_o = (state_q == IDLE) ||
                            ((state_q == SEND) && last_word && data_ready_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (result_valid_i) begin
                    cap_d   = result_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (data_ready_i) begin
                    if (!last_word) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (result_valid_i) begin
                            cap_d = result_i;
                            cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == SEND);
        data_d  = valid_d ? sel_word(cap_d, cnt_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign data_o        = data_q;
    assign data_valid_o  = valid_q;
    assign unload_done_o = done_q;

endmodule

// File: doc/dataunload.md
# dataunload

Result serializer at the output end of the compute array: captures one 256-bit result vector (eight 32-bit words) in parallel and streams it out one word per handshake on a 32-bit valid/ready bus. It mirrors `dataload`'s word format, so a vector unloaded here and fed back through `dataload` is reconstructed bit-exactly. It sits between the array's result stage and the host readback path.

## Interface
Parameters:
- `WORD_WIDTH`, 32: width of one output word.
- `NUM_WORDS`, 8: words per result vector; result width is `WORD_WIDTH*NUM_WORDS`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `result_i`, input, 256: parallel result vector.
- `result_valid_i`, input, 1: `result_i` is valid.
- `result_ready_o`, output, 1: block can capture a new vector this cycle.
- `data_o`, output, 32: current output word.
- `data_valid_o`, output, 1: `data_o` is valid.
- `data_ready_i`, input, 1: consumer accepts `data_o` this cycle.
- `unload_done_o`, output, 1: one-cycle pulse after the last word of a vector is accepted.

## Operation
- Capture handshake: `result_valid_i && result_ready_o`. Word handshake: `data_valid_o && data_ready_i`.
- FSM states:
  - IDLE: `data_valid_o` = 0 and `result_ready_o` = 1. On capture, latch `result_i`, clear the word counter `cnt`, and go to SEND.
  - SEND: `data_valid_o` = 1 and `data_o` = word[`cnt`].
    - Word handshake with `cnt < NUM_WORDS-1`: increment `cnt`.
    - Word handshake with `cnt == NUM_WORDS-1` (last word): pulse `unload_done_o` next cycle. If a capture happens in the same cycle, latch the new vector, set `cnt` to 0 and stay in SEND; otherwise go to IDLE.
- `result_ready_o` = (state == IDLE) || (state == SEND && `cnt == NUM_WORDS-1` && `data_ready_i`). This gives zero-bubble back-to-back vectors. It is combinational from `data_ready_i`.
- Word order (default): word k = `result_i[32k+31:32k]`; word 0 is sent first.
- `data_o` and `data_valid_o` hold stable while `data_valid_o && !data_ready_i`. Stall length is unlimited.
- `result_valid_i` is ignored while `result_ready_o` = 0. The upstream stage holds its data.
- `cnt` is `$clog2(NUM_WORDS)` bits wide. It never wraps past `NUM_WORDS-1`.

## Timing
- Reset values: state IDLE, `cnt` 0, capture register 0, `data_o` 0, `data_valid_o` 0, `unload_done_o` 0. `result_ready_o` = 1 while and after reset.
- Latency: a capture at edge N makes word 0 valid from cycle N+1.
- With `data_ready_i` held at 1, eight words go out in cycles N+1 to N+8 and `unload_done_o` is high in cycle N+9.
- Back-to-back throughput is `NUM_WORDS` cycles per vector with no idle cycle.
- `unload_done_o` is registered: high for exactly one cycle, the cycle after the last-word handshake. This holds even when the next vector starts in that same cycle.
- Reset asserted mid-vector: the partial vector is abandoned and all outputs go to their reset values at once. No `unload_done_o` pulse is produced.

## Configuration
- `DATAUNLOAD_MSW_FIRST_EN`
  - Defined: word order is reversed. Word `NUM_WORDS-1` (bits [255:224]) is sent first and word 0 last; all handshake and timing rules are unchanged.
  - Undefined: least-significant word first, as described under Operation.

## Structure
- Shared package `dataload_pkg` holds:
  - `WORD_WIDTH` and `NUM_WORDS` constants;
  - `unload_state_t` enum {IDLE, SEND};
  - a `result_vec_t` typedef (`logic [WORD_WIDTH*NUM_WORDS-1:0]`).
  `dataload` and `dataunload` share this package.
- No sub-module. The capture register, counter-indexed word mux and FSM form one module.

## Test plan
- Single vector, ready always 1: `result_i` = {32'h7,…,32'h0} → `data_o` = 0,1,…,7 in cycles N+1..N+8; `unload_done_o` high only in N+9.
- Backpressure: drop `data_ready_i` for 3 cycles while word 2 is showing → `data_o` holds 32'h2 with `data_valid_o` high; word 3 follows the first ready cycle.
- Back-to-back: vectors A and B offered continuously → 16 consecutive valid words with no gap; `result_ready_o` high only in IDLE and on A's last-word handshake cycle.
- Reset mid-vector: deassert `rst_n` after word 4 → `data_valid_o` and `data_o` are 0 immediately, no done pulse; after reset a new vector starts again from word 0.
- Loopback: pipe `data_o` into `dataload` with `load_type` = 1 → `first_level_input_data` equals the original `result_i` and `input_valid` asserts. Run with and without `DATAUNLOAD_MSW_FIRST_EN`; only the word order differs.
